wb_test_monitor: RTL and testbench
==================================

WB_TEST_MONITOR -- requirements
Module: wb_test_monitor

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent test channels (legal 1..8).
REQ-002 SHALL have parameter TIMEOUT_W, default 24, watchdog counter width in bits (legal 8..32).
REQ-003 SHALL have parameter DEFAULT_TIMEOUT, default 70000, watchdog reload value after reset, in clock cycles.
REQ-004 SHALL have port clock  input  1  single clock for all logic.
REQ-005 SHALL have port resetb  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic slave strobes.
REQ-007 SHALL have ports wbs_adr_i  input  32, wbs_dat_i  input  32, wbs_sel_i  input  4  Wishbone address, write data, byte select.
REQ-008 SHALL have ports wbs_ack_o  output  1, wbs_dat_o  output  32  Wishbone acknowledge and read data.
REQ-009 SHALL have port fail_o  output  1  high while any channel is in FAIL or TMO.
REQ-010 SHALL have port pass_o  output  1  high while every channel is in PASS.
REQ-011 SHALL have port done_o  output  1  high while every channel is in PASS, FAIL or TMO.
REQ-012 SHALL have port irq_o  output  1  one-cycle pulse when any channel enters PASS, FAIL or TMO.

Function
REQ-013 Bus: request = cyc&stb and not ack; ack SHALL assert exactly one cycle after request, for one cycle; writes take effect on the ack cycle.
REQ-014 Decode on wbs_adr_i[7:2]; writes honour only sel[0]; unmapped reads SHALL return 0; unmapped writes SHALL be ignored but acked.
REQ-015 0x00 CTRL: read {16'h0, CHANNELS[7:0], 8'h01}; write dat[0]=1 SHALL return all channels to IDLE with counters cleared.
REQ-016 0x04 TIMEOUT: R/W, low TIMEOUT_W bits; value 0 SHALL disable the watchdog.
REQ-017 0x08 SUMMARY: RO, [7:0] pass mask, [15:8] fail/timeout mask, one bit per channel, unused bits 0.
REQ-018 0x10+4*n CHn: write dat[1:0] command (0 START, 1 CHECKPOINT, 2 PASS, 3 FAIL), dat[7:4] required checkpoints (START only); read {state[2:0] at [2:0], ckpt count [7:4], required [11:8]}.
REQ-019 Channel FSM states IDLE, RUN, PASS, FAIL, TMO; reset state IDLE.
REQ-020 START from any state SHALL enter RUN, clear ckpt count, latch required, load watchdog with TIMEOUT.
REQ-021 In RUN: CHECKPOINT SHALL increment ckpt count, saturating at 15, and reload watchdog; FAIL SHALL enter FAIL.
REQ-022 In RUN: PASS SHALL enter PASS if ckpt count >= required, else FAIL.
REQ-023 CHECKPOINT or PASS in IDLE SHALL enter FAIL (protocol violation); FAIL in IDLE SHALL enter FAIL.
REQ-024 In PASS, FAIL, TMO all commands except START SHALL be ignored.
REQ-025 Watchdog in RUN decrements by 1 per cycle when TIMEOUT != 0; on reaching 0 the channel SHALL enter TMO the next cycle.
REQ-026 A channel command on the cycle of watchdog expiry SHALL take priority over expiry.
REQ-027 Writing TIMEOUT SHALL not affect running counters; new value applies at next START/CHECKPOINT.
REQ-028 fail_o, pass_o, done_o SHALL be registered, reflecting state one cycle after the transition; irq_o pulses in that same cycle.

Reset
REQ-029 resetb low SHALL asynchronously force: all channels IDLE, counts 0, TIMEOUT=DEFAULT_TIMEOUT, wbs_ack_o=0, wbs_dat_o=0, fail_o=0, pass_o=0, done_o=0, irq_o=0.
REQ-030 A bus request in flight at reset SHALL be dropped without ack; release SHALL be synchronised by the integrating design.

Structure
REQ-031 Package tmon_pkg SHALL hold state encoding (IDLE=0..TMO=4), command codes, register offsets and version constant.
REQ-032 Per-channel FSM, ckpt counter and watchdog SHALL be sub-module tmon_channel, instantiated CHANNELS times by generate.

Verification
REQ-033 TIMEOUT=100, CH0 START req=2, two CHECKPOINT, PASS -> CH0 state PASS, ckpt=2, irq_o one pulse, fail_o=0.
REQ-034 CH0 START req=3, one CHECKPOINT, PASS -> CH0 FAIL, fail_o=1, SUMMARY=0x0100.
REQ-035 TIMEOUT=50, CH1 START, no writes -> CH1 TMO 51 cycles after START ack (±1), fail_o=1, SUMMARY[9]=1.
REQ-036 CHANNELS=2, both START req=0 then PASS -> pass_o=1, done_o=1; CTRL write 1 -> both IDLE, pass_o=0.
REQ-037 CHECKPOINT on expiry cycle with TIMEOUT=10 -> no TMO, count=1; CHECKPOINT in IDLE -> FAIL; resetb low mid-RUN -> IDLE, TIMEOUT reads 70000.

Source files
------------

// File: rtl/tmon_pkg.sv
// rtl/tmon_pkg.sv - shared encodings and register map for the test monitor
package tmon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3,
        ST_TMO  = 3'd4
    } tmon_state_e;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_CKPT  = 2'd1,
        CMD_PASS  = 2'd2,
        CMD_FAIL  = 2'd3
    } tmon_cmd_e;

    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_TIMEOUT = 8'h04;
    localparam logic [7:0] OFF_SUMMARY = 8'h08;
    localparam logic [7:0] OFF_CH0     = 8'h10;
    localparam logic [7:0] VERSION     = 8'h01;

    // Decode is on word address, so the maps are compared on bits [7:2].
    localparam logic [5:0] IDX_CTRL    = OFF_CTRL[7:2];
    localparam logic [5:0] IDX_TIMEOUT = OFF_TIMEOUT[7:2];
    localparam logic [5:0] IDX_SUMMARY = OFF_SUMMARY[7:2];
    localparam logic [5:0] IDX_CH0     = OFF_CH0[7:2];

    function automatic logic is_terminal(input tmon_state_e s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TMO);
    endfunction

endpackage

// File: rtl/tmon_channel.sv
// rtl/tmon_channel.sv - one test channel: verdict FSM, checkpoint counter, watchdog
module tmon_channel
    import tmon_pkg::*;
#(
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic                 clear_i,
    input  logic                 cmd_valid_i,
    input  logic [1:0]           cmd_i,
    input  logic [3:0]           required_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output tmon_state_e          state_o,
    output logic [3:0]           ckpt_o,
    output logic [3:0]           required_o
);

    tmon_state_e          state_q, state_d;
    logic [3:0]           ckpt_q, ckpt_d;
    logic [3:0]           req_q, req_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 wd_en_q, wd_en_d;
    tmon_cmd_e            cmd;

    always_comb begin
        state_d = state_q;
        ckpt_d  = ckpt_q;
        req_d   = req_q;
        wd_d    = wd_q;
        wd_en_d = wd_en_q;
        cmd     = tmon_cmd_e'(cmd_i);
        if (clear_i) begin
            state_d = ST_IDLE;
            ckpt_d  = '0;
            req_d   = '0;
            wd_d    = '0;
            wd_en_d = 1'b0;
        end else if (cmd_valid_i) begin
            // A command on the expiry cycle wins, so expiry sits in the last branch.
            if (cmd == CMD_START) begin
                state_d = ST_RUN;
                ckpt_d  = '0;
                req_d   = required_i;
                wd_d    = timeout_i;
                wd_en_d = |timeout_i;
            end else if (state_q == ST_IDLE) begin
                state_d = ST_FAIL;
            end else if (state_q == ST_RUN) begin
                case (cmd)
                    CMD_CKPT: begin
                        if (ckpt_q != 4'hF) ckpt_d = ckpt_q + 4'd1;
                        wd_d    = timeout_i;
                        wd_en_d = |timeout_i;
                    end
                    CMD_PASS: state_d = (ckpt_q >= req_q) ? ST_PASS : ST_FAIL;
                    CMD_FAIL: state_d = ST_FAIL;
                    default:  ;
                endcase
            end
        end else if ((state_q == ST_RUN) && wd_en_q) begin
            if (wd_q == '0) state_d = ST_TMO;
            else            wd_d    = wd_q - TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
            ckpt_q  <= '0;
            req_q   <= '0;
            wd_q    <= '0;
            wd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ckpt_q  <= ckpt_d;
            req_q   <= req_d;
            wd_q    <= wd_d;
            wd_en_q <= wd_en_d;
        end
    end

    assign state_o    = state_q;
    assign ckpt_o     = ckpt_q;
    assign required_o = req_q;

endmodule

// File: rtl/wb_test_monitor.sv
// rtl/wb_test_monitor.sv - Wishbone-mapped multi-channel self-test verdict monitor
module wb_test_monitor
    import tmon_pkg::*;
#(
    parameter int          CHANNELS        = 2,
    parameter int          TIMEOUT_W       = 24,
    parameter int unsigned DEFAULT_TIMEOUT = 70000
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        fail_o,
    output logic        pass_o,
    output logic        done_o,
    output logic        irq_o
);

    logic                 ack_q, ack_d;
    logic [31:0]          dat_q, dat_d;
    logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
    logic                 pass_q, fail_q, done_q, irq_q;
    logic [CHANNELS-1:0]  term_q;

    logic                 bus_req, wr_en, clear;
    logic [5:0]           adr_idx;
    logic [31:0]          rdata;
    logic [CHANNELS-1:0]  pass_mask, fail_mask, term_mask;
    tmon_state_e          ch_state [CHANNELS];
    logic [3:0]           ch_ckpt  [CHANNELS];
    logic [3:0]           ch_req   [CHANNELS];
    logic [31:0]          ch_rdata [CHANNELS];
    logic                 unused_bits;

    assign adr_idx = wbs_adr_i[7:2];
    assign bus_req = wbs_cyc_i & wbs_stb_i & ~ack_q;
    // Writes land on the ack cycle, while the master still holds address and data.
    assign wr_en   = ack_q & wbs_cyc_i & wbs_stb_i & wbs_we_i & wbs_sel_i[0];
    assign clear   = wr_en && (adr_idx == IDX_CTRL) && wbs_dat_i[0];

    assign ack_d     = bus_req;
    assign dat_d     = bus_req ? rdata : 32'h0;
    assign timeout_d = (wr_en && (adr_idx == IDX_TIMEOUT)) ? wbs_dat_i[TIMEOUT_W-1:0] : timeout_q;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        tmon_channel #(
            .TIMEOUT_W (TIMEOUT_W)
        ) u_ch (
            .clock       (clock),
            .resetb      (resetb),
            .clear_i     (clear),
            .cmd_valid_i (wr_en && (adr_idx == IDX_CH0 + 6'(n))),
            .cmd_i       (wbs_dat_i[1:0]),
            .required_i  (wbs_dat_i[7:4]),
            .timeout_i   (timeout_q),
            .state_o     (ch_state[n]),
            .ckpt_o      (ch_ckpt[n]),
            .required_o  (ch_req[n])
        );
        assign ch_rdata[n]  = {20'h0, ch_req[n], ch_ckpt[n], 1'b0, ch_state[n]};
        assign pass_mask[n] = (ch_state[n] == ST_PASS);
        assign fail_mask[n] = (ch_state[n] == ST_FAIL) || (ch_state[n] == ST_TMO);
        assign term_mask[n] = is_terminal(ch_state[n]);
    end

    always_comb begin
        rdata = 32'h0;
        if (adr_idx == IDX_CTRL)         rdata = {16'h0, 8'(CHANNELS), VERSION};
        else if (adr_idx == IDX_TIMEOUT) rdata = 32'(timeout_q);
        else if (adr_idx == IDX_SUMMARY) rdata = {16'h0, 8'(fail_mask), 8'(pass_mask)};
        for (int n = 0; n < CHANNELS; n++) begin
            if (adr_idx == IDX_CH0 + 6'(n)) rdata = ch_rdata[n];
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            ack_q     <= 1'b0;
            dat_q     <= 32'h0;
            timeout_q <= TIMEOUT_W'(DEFAULT_TIMEOUT);
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
            term_q    <= '0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            timeout_q <= timeout_d;
            pass_q    <= &pass_mask;
            fail_q    <= |fail_mask;
            done_q    <= &term_mask;
            term_q    <= term_mask;
            // A channel is newly terminal when it was not terminal one cycle earlier.
            irq_q     <= |(term_mask & ~term_q);
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign pass_o    = pass_q;
    assign fail_o    = fail_q;
    assign done_o    = done_q;
    assign irq_o     = irq_q;

    assign unused_bits = &{1'b0, wbs_adr_i[31:8], wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i};

endmodule

// File: tb/tb_wb_test_monitor.sv
// tb/tb_wb_test_monitor.sv - directed self-checking bench for wb_test_monitor
module tb_wb_test_monitor;

    logic        clock = 1'b0;
    logic        resetb;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_w;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] dat_r;
    logic        fail_o, pass_o, done_o, irq_o;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          irq_cnt = 0;
    logic [3:0]  bus_sel = 4'hF;
    logic [31:0] rd;
    logic        acked;

    wb_test_monitor dut (
        .clock     (clock),
        .resetb    (resetb),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat_w),
        .wbs_sel_i (sel),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_r),
        .fail_o    (fail_o),
        .pass_o    (pass_o),
        .done_o    (done_o),
        .irq_o     (irq_o)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (irq_o === 1'b1) irq_cnt++;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, output logic ok);
        @(posedge clock); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = bus_sel;
        @(posedge clock); #1;
        ok = ack;
        @(posedge clock); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output logic ok);
        @(posedge clock); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        @(posedge clock); #1;
        ok = ack; d = dat_r;
        @(posedge clock); #1;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetb = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = '0;
        repeat (3) @(posedge clock);
        #1;
        tests_run++; if ({ack, fail_o, pass_o, done_o, irq_o} !== 5'b0) begin tests_failed++; $display("FAIL reset_outputs: got %b expected 00000", {ack, fail_o, pass_o, done_o, irq_o}); end
        tests_run++; if (dat_r !== 32'h0) begin tests_failed++; $display("FAIL reset_dat: got %h expected 0", dat_r); end
        @(negedge clock) resetb = 1'b1;
        wb_read(32'h00, rd, acked);
        tests_run++; if (rd !== 32'h0000_0201) begin tests_failed++; $display("FAIL ctrl_read: got %h expected 00000201", rd); end
        wb_read(32'h04, rd, acked);
        tests_run++; if (rd !== 32'd70000) begin tests_failed++; $display("FAIL timeout_default: got %0d expected 70000", rd); end
        wb_read(32'h10, rd, acked);
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL ch0_reset: got %h expected 0", rd); end
    endtask

    task automatic test_bus();
        @(posedge clock); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h08; sel = 4'hF;
        tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL ack_early: got %b expected 0", ack); end
        @(posedge clock); #1;
        tests_run++; if (ack !== 1'b1) begin tests_failed++; $display("FAIL ack_latency: got %b expected 1", ack); end
        @(posedge clock); #1;
        tests_run++; if (ack !== 1'b0) begin tests_failed++; $display("FAIL ack_width: got %b expected 0", ack); end
        cyc = 1'b0; stb = 1'b0;
        wb_read(32'h3C, rd, acked);
        tests_run++; if ({acked, rd} !== {1'b1, 32'h0}) begin tests_failed++; $display("FAIL unmapped_read: got ack=%b dat=%h expected ack=1 dat=0", acked, rd); end
        wb_read(32'h18, rd, acked);
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL absent_channel_read: got %h expected 0", rd); end
        wb_write(32'h40, 32'hFFFF_FFFF, acked);
        tests_run++; if (acked !== 1'b1) begin tests_failed++; $display("FAIL unmapped_write_ack: got %b expected 1", acked); end
        bus_sel = 4'hE;
        wb_write(32'h04, 32'h55, acked);
        bus_sel = 4'hF;
        wb_read(32'h04, rd, acked);
        tests_run++; if (rd !== 32'd70000) begin tests_failed++; $display("FAIL sel0_gating: got %0d expected 70000", rd); end
    endtask

    task automatic test_pass();
        int base;
        wb_write(32'h04, 32'd100, acked);
        base = irq_cnt;
        wb_write(32'h10, 32'h20, acked);
        wb_write(32'h10, 32'h01, acked);
        wb_write(32'h10, 32'h01, acked);
        wb_write(32'h10, 32'h02, acked);
        settle();
        tests_run++; if (irq_cnt - base !== 1) begin tests_failed++; $display("FAIL pass_irq_count: got %0d expected 1", irq_cnt - base); end
        tests_run++; if (fail_o !== 1'b0) begin tests_failed++; $display("FAIL pass_fail_o: got %b expected 0", fail_o); end
        wb_read(32'h10, rd, acked);
        tests_run++; if (rd !== 32'h0000_0222) begin tests_failed++; $display("FAIL pass_ch0: got %h expected 00000222", rd); end
    endtask

    task automatic test_fail_short();
        wb_write(32'h10, 32'h30, acked);
        wb_write(32'h10, 32'h01, acked);
        wb_write(32'h10, 32'h02, acked);
        settle();
        tests_run++; if (fail_o !== 1'b1) begin tests_failed++; $display("FAIL short_fail_o: got %b expected 1", fail_o); end
        wb_read(32'h10, rd, acked);
        tests_run++; if (rd !== 32'h0000_0313) begin tests_failed++; $display("FAIL short_ch0: got %h expected 00000313", rd); end
        wb_read(32'h08, rd, acked);
        tests_run++; if (rd !== 32'h0000_0100) begin tests_failed++; $display("FAIL short_summary: got %h expected 00000100", rd); end
    endtask

    task automatic test_timeout();
        int cycles;
        wb_write(32'h00, 32'h1, acked);
        wb_write(32'h04, 32'd50, acked);
        wb_write(32'h14, 32'h00, acked);
        cycles = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clock); #1;
            if (irq_o === 1'b1) begin cycles = i; break; end
        end
        tests_run++; if (cycles < 51 || cycles > 53) begin tests_failed++; $display("FAIL tmo_latency: got %0d cycles expected 51..53", cycles); end
        tests_run++; if (fail_o !== 1'b1) begin tests_failed++; $display("FAIL tmo_fail_o: got %b expected 1", fail_o); end
        wb_read(32'h08, rd, acked);
        tests_run++; if (rd !== 32'h0000_0200) begin tests_failed++; $display("FAIL tmo_summary: got %h expected 00000200", rd); end
        wb_read(32'h14, rd, acked);
        tests_run++; if (rd !== 32'h0000_0004) begin tests_failed++; $display("FAIL tmo_ch1: got %h expected 00000004", rd); end
    endtask

    task automatic test_all_pass();
        wb_write(32'h00, 32'h1, acked);
        wb_write(32'h10, 32'h00, acked);
        wb_write(32'h14, 32'h00, acked);
        wb_write(32'h10, 32'h02, acked);
        wb_write(32'h14, 32'h02, acked);
        settle();
        tests_run++; if ({pass_o, done_o, fail_o} !== 3'b110) begin tests_failed++; $display("FAIL all_pass_flags: got pass/done/fail=%b expected 110", {pass_o, done_o, fail_o}); end
        wb_read(32'h08, rd, acked);
        tests_run++; if (rd !== 32'h0000_0003) begin tests_failed++; $display("FAIL all_pass_summary: got %h expected 00000003", rd); end
        wb_write(32'h00, 32'h1, acked);
        settle();
        tests_run++; if ({pass_o, done_o} !== 2'b00) begin tests_failed++; $display("FAIL clear_flags: got pass/done=%b expected 00", {pass_o, done_o}); end
        wb_read(32'h10, rd, acked);
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL clear_ch0: got %h expected 0", rd); end
        wb_read(32'h14, rd, acked);
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL clear_ch1: got %h expected 0", rd); end
    endtask

    task automatic test_boundary();
        wb_write(32'h04, 32'd10, acked);
        wb_write(32'h10, 32'h00, acked);
        // START applies at edge E2; counter hits 0 after E12, so CHECKPOINT must apply at E13.
        repeat (8) @(posedge clock);
        wb_write(32'h10, 32'h01, acked);
        wb_read(32'h10, rd, acked);
        tests_run++; if (rd !== 32'h0000_0011) begin tests_failed++; $display("FAIL expiry_priority: got %h expected 00000011", rd); end
        wb_write(32'h04, 32'd0, acked);
        wb_write(32'h14, 32'h00, acked);
        for (int i = 0; i < 16; i++) wb_write(32'h14, 32'h01, acked);
        wb_read(32'h14, rd, acked);
        tests_run++; if (rd !== 32'h0000_00F1) begin tests_failed++; $display("FAIL ckpt_saturate: got %h expected 000000f1", rd); end
    endtask

    task automatic test_idle_violation();
        wb_write(32'h00, 32'h1, acked);
        wb_write(32'h10, 32'h01, acked);
        wb_read(32'h10, rd, acked);
        tests_run++; if (rd !== 32'h0000_0003) begin tests_failed++; $display("FAIL idle_ckpt: got %h expected 00000003", rd); end
        wb_write(32'h10, 32'h02, acked);
        wb_read(32'h10, rd, acked);
        tests_run++; if (rd !== 32'h0000_0003) begin tests_failed++; $display("FAIL fail_ignores_pass: got %h expected 00000003", rd); end
    endtask

    task automatic test_reset_mid_run();
        wb_write(32'h04, 32'd1000, acked);
        wb_write(32'h14, 32'h00, acked);
        settle();
        tests_run++; if (fail_o !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_fail_o: got %b expected 1", fail_o); end
        @(posedge clock); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h00;
        @(posedge clock); #1;
        tests_run++; if (ack !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_ack: got %b expected 1", ack); end
        #2 resetb = 1'b0;
        #1;
        tests_run++; if ({ack, fail_o, dat_r} !== {2'b00, 32'h0}) begin tests_failed++; $display("FAIL async_reset: got ack=%b fail=%b dat=%h expected 0 0 0", ack, fail_o, dat_r); end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clock) resetb = 1'b1;
        wb_read(32'h14, rd, acked);
        tests_run++; if (rd !== 32'h0) begin tests_failed++; $display("FAIL reset_ch1_idle: got %h expected 0", rd); end
        wb_read(32'h04, rd, acked);
        tests_run++; if (rd !== 32'd70000) begin tests_failed++; $display("FAIL reset_timeout: got %0d expected 70000", rd); end
    endtask

    initial begin
        test_reset();
        test_bus();
        test_pass();
        test_fail_short();
        test_timeout();
        test_all_pass();
        test_boundary();
        test_idle_violation();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
